// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the program-counter / next-PC stage.
//   PC_W       : program counter width (32)
//   IDX_W      : J-type instr_index width (26)
//   PC_INC     : sequential fetch increment (4)
//   pc_state_e : fetch FSM states (INIT, FETCH, PENDING)
//   redirect_t : a resolved control-transfer target plus its alignment error
// Optional feature macro used by the files importing this package:
//   PC_ALIGN_CHECK_EN
// -----------------------------------------------------------------------------
package pc_pkg;

  localparam int PC_W  = 32;
  localparam int IDX_W = 26;

  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PENDING = 2'd2
  } pc_state_e;

  // A redirect as it will be applied to the PC: the final target (exception
  // vector already substituted when applicable) and whether the load must
  // raise AddrErr.
  typedef struct packed {
    logic [PC_W-1:0] target;
    logic            err;
  } redirect_t;

endpackage : pc_pkg

// File: rtl/pc_target_sel.sv
// -----------------------------------------------------------------------------
// pc_target_sel
// Combinational next-PC target selection for control transfers.
// Priority: JR/JALR > J/JAL > taken conditional branch.
//   branch_base   in  32  PC+4 of the branch/jump instruction
//   branch_offset in  32  sign-extended immediate << 2
//   branch_taken  in  1   conditional branch resolved taken
//   jump          in  1   J/JAL
//   jump_index    in  26  instr_index field
//   jump_reg      in  1   JR/JALR
//   jump_reg_addr in  32  rs value
//   redirect      out 1   any control transfer requested
//   sel           out     selected target and alignment-error flag
// Macro PC_ALIGN_CHECK_EN: a misaligned JR/JALR target is replaced by
// EXC_VECTOR and flagged; otherwise the low two address bits are dropped.
// -----------------------------------------------------------------------------
module pc_target_sel
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic [PC_W-1:0]  branch_base,
  input  logic [PC_W-1:0]  branch_offset,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic [IDX_W-1:0] jump_index,
  input  logic             jump_reg,
  input  logic [PC_W-1:0]  jump_reg_addr,
  output logic             redirect,
  output redirect_t        sel
);

  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] jump_target;
  logic [PC_W-1:0] jr_target;
  logic            jr_err;

  // Plain modulo-2^32 add; overflow is deliberately not reported.
  assign branch_target = branch_base + branch_offset;

  // J-type target keeps the 256 MB region of the delay-slot PC.
  assign jump_target = {branch_base[PC_W-1:PC_W-4], jump_index, 2'b00};

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned;

  assign misaligned = |jump_reg_addr[1:0];
  assign jr_target  = misaligned ? EXC_VECTOR : jump_reg_addr;
  assign jr_err     = misaligned;
`else
  logic unused_low_bits;
  logic unused_exc_vector;

  // Without checking, a register target is simply forced word-aligned.
  assign jr_target         = {jump_reg_addr[PC_W-1:2], 2'b00};
  assign jr_err            = 1'b0;
  assign unused_low_bits   = ^jump_reg_addr[1:0];
  assign unused_exc_vector = ^EXC_VECTOR;
`endif

  assign redirect = jump_reg | jump | branch_taken;

  always_comb begin
    sel = '0;
    if (jump_reg) begin
      sel.target = jr_target;
      sel.err    = jr_err;
    end else if (jump) begin
      sel.target = jump_target;
    end else if (branch_taken) begin
      sel.target = branch_target;
    end
  end

endmodule : pc_target_sel

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program counter register, sequential fetch, and a one-entry redirect buffer
// that holds a control transfer arriving while the pipeline is stalled.
//   Clk          in  1   clock, rising edge
//   Rst          in  1   synchronous active-low reset
//   Stall        in  1   hazard stall; PC must not advance
//   ImemReady    in  1   instruction memory accepts the current fetch
//   BranchBase   in  32  PC+4 of the branch/jump instruction
//   BranchOffset in  32  sign-extended immediate << 2
//   BranchTaken  in  1   conditional branch taken
//   Jump         in  1   J/JAL
//   JumpIndex    in  26  instr_index field
//   JumpReg      in  1   JR/JALR
//   JumpRegAddr  in  32  rs value
//   PC           out 32  current fetch address
//   PCPlus4      out 32  PC + 4 (combinational from PC register)
//   PCValid      out 1   fetch request valid
//   AddrErr      out 1   one-cycle pulse when a misaligned JR target loads
// Macro PC_ALIGN_CHECK_EN enables JR alignment checking; when undefined
// AddrErr is tied low.
// -----------------------------------------------------------------------------
module pc_unit
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic             ImemReady,
  input  logic [PC_W-1:0]  BranchBase,
  input  logic [PC_W-1:0]  BranchOffset,
  input  logic             BranchTaken,
  input  logic             Jump,
  input  logic [IDX_W-1:0] JumpIndex,
  input  logic             JumpReg,
  input  logic [PC_W-1:0]  JumpRegAddr,
  output logic [PC_W-1:0]  PC,
  output logic [PC_W-1:0]  PCPlus4,
  output logic             PCValid,
  output logic             AddrErr
);

  pc_state_e       state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  redirect_t       pend_reg, pend_next;
  logic            addr_err_reg, addr_err_next;

  logic            redirect;
  redirect_t       sel;
  redirect_t       chosen;

  pc_target_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_target_sel (
    .branch_base   (BranchBase),
    .branch_offset (BranchOffset),
    .branch_taken  (BranchTaken),
    .jump          (Jump),
    .jump_index    (JumpIndex),
    .jump_reg      (JumpReg),
    .jump_reg_addr (JumpRegAddr),
    .redirect      (redirect),
    .sel           (sel)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_reg <= ST_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT:    state_next = ST_FETCH;
      ST_FETCH:   if (redirect && Stall) state_next = ST_PENDING;
      ST_PENDING: if (!Stall) state_next = ST_FETCH;
      default:    state_next = ST_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    PCValid = 1'b0;
    case (state_reg)
      ST_FETCH, ST_PENDING: PCValid = 1'b1;
      default:              PCValid = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values: PC, redirect buffer, error pulse
  // ---------------------------------------------------------------------------
  // A redirect present in the same cycle the stall releases is younger than
  // the buffered one, so it wins.
  assign chosen = redirect ? sel : pend_reg;

  always_comb begin
    pc_next       = pc_reg;
    pend_next     = pend_reg;
    addr_err_next = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        if (redirect) begin
          if (!Stall) begin
            // Redirect abandons the outstanding fetch even if memory
            // accepted it this cycle.
            pc_next       = sel.target;
            addr_err_next = sel.err;
          end else begin
            pend_next = sel;
          end
        end else if (ImemReady && !Stall) begin
          pc_next = pc_reg + PC_INC;
        end
      end
      ST_PENDING: begin
        if (Stall) begin
          if (redirect) pend_next = sel;
        end else begin
          pc_next       = chosen.target;
          addr_err_next = chosen.err;
          pend_next     = '0;
        end
      end
      default: begin
        pc_next = RESET_PC;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      pc_reg       <= RESET_PC;
      pend_reg     <= '0;
      addr_err_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      pend_reg     <= pend_next;
      addr_err_reg <= addr_err_next;
    end
  end

  assign PC      = pc_reg;
  assign PCPlus4 = pc_reg + PC_INC;

`ifdef PC_ALIGN_CHECK_EN
  assign AddrErr = addr_err_reg;
`else
  logic unused_addr_err;

  assign AddrErr         = 1'b0;
  assign unused_addr_err = addr_err_reg;
`endif

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
// Self-checking bench for pc_unit: directed scenarios with literal
// expectations, then randomized stimulus checked every cycle against a
// behavioural model. Honours PC_ALIGN_CHECK_EN for the expected values.
// -----------------------------------------------------------------------------
module tb_pc_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Stall;
  logic        ImemReady;
  logic [31:0] BranchBase;
  logic [31:0] BranchOffset;
  logic        BranchTaken;
  logic        Jump;
  logic [25:0] JumpIndex;
  logic        JumpReg;
  logic [31:0] JumpRegAddr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        PCValid;
  logic        AddrErr;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model state
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_err;
  bit          m_have_pend;
  logic [31:0] m_pend_pc;
  bit          m_pend_err;

  pc_unit #(
    .RESET_PC   (RESET_PC),
    .EXC_VECTOR (EXC_VECTOR)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Stall        (Stall),
    .ImemReady    (ImemReady),
    .BranchBase   (BranchBase),
    .BranchOffset (BranchOffset),
    .BranchTaken  (BranchTaken),
    .Jump         (Jump),
    .JumpIndex    (JumpIndex),
    .JumpReg      (JumpReg),
    .JumpRegAddr  (JumpRegAddr),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .PCValid      (PCValid),
    .AddrErr      (AddrErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Where a control transfer sends the PC, and whether it is an address error.
  task automatic model_target(output logic [31:0] tgt, output bit err);
    err = 1'b0;
    tgt = 32'h0;
    if (JumpReg) begin
`ifdef PC_ALIGN_CHECK_EN
      if (JumpRegAddr % 4 != 0) begin
        tgt = EXC_VECTOR;
        err = 1'b1;
      end else begin
        tgt = JumpRegAddr;
      end
`else
      tgt = JumpRegAddr - (JumpRegAddr % 4);
`endif
    end else if (Jump) begin
      tgt = (BranchBase & 32'hF000_0000) | (32'(JumpIndex) * 4);
    end else if (BranchTaken) begin
      tgt = BranchBase + BranchOffset;
    end
  endtask

  // Behavioural model: advances once per rising edge from the sampled inputs.
  always @(posedge Clk) begin
    logic [31:0] tgt;
    bit          terr;
    bit          redir;
    model_target(tgt, terr);
    redir = JumpReg || Jump || BranchTaken;
    if (Rst !== 1'b1) begin
      m_pc        = RESET_PC;
      m_valid     = 1'b0;
      m_err       = 1'b0;
      m_have_pend = 1'b0;
    end else if (!m_valid) begin
      m_valid = 1'b1;
      m_err   = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_have_pend) begin
        if (!Stall) begin
          m_pc        = redir ? tgt : m_pend_pc;
          m_err       = redir ? terr : m_pend_err;
          m_have_pend = 1'b0;
        end else if (redir) begin
          m_pend_pc  = tgt;
          m_pend_err = terr;
        end
      end else if (redir) begin
        if (!Stall) begin
          m_pc  = tgt;
          m_err = terr;
        end else begin
          m_have_pend = 1'b1;
          m_pend_pc   = tgt;
          m_pend_err  = terr;
        end
      end else if (ImemReady && !Stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Compare process: every cycle once the first reset has been applied.
  always @(negedge Clk) begin
    if (check_en) begin
      chk("pc", PC, m_pc);
      chk("pcplus4", PCPlus4, m_pc + 32'd4);
      chk("pcvalid", {31'b0, PCValid}, {31'b0, m_valid});
      chk("addrerr", {31'b0, AddrErr}, {31'b0, m_err});
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic idle_ctl();
    BranchTaken = 1'b0;
    Jump        = 1'b0;
    JumpReg     = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [31:0] exp_pc, input bit exp_valid, input bit exp_err);
    $display("txn %s: PC=%h valid=%0b err=%0b", nm, PC, PCValid, AddrErr);
    chk({nm, "_pc"}, PC, exp_pc);
    chk({nm, "_valid"}, {31'b0, PCValid}, {31'b0, exp_valid});
    chk({nm, "_err"}, {31'b0, AddrErr}, {31'b0, exp_err});
  endtask

  initial begin
    Rst = 1'b0; Stall = 1'b0; ImemReady = 1'b1;
    BranchBase = '0; BranchOffset = '0; JumpIndex = '0; JumpRegAddr = '0;
    idle_ctl();

    // Reset and release
    tick();
    check_en = 1'b1;
    tick();
    lit("reset", 32'h0, 1'b0, 1'b0);
    chk("reset_pcplus4", PCPlus4, 32'h4);
    Rst = 1'b1;
    lit("rel0", 32'h0, 1'b0, 1'b0);
    tick(); lit("rel1", 32'h0, 1'b1, 1'b0);
    tick(); lit("rel2", 32'h4, 1'b1, 1'b0);
    tick(); lit("rel3", 32'h8, 1'b1, 1'b0);

    // Branch with negative offset from PC=0x100
    JumpReg = 1'b1; JumpRegAddr = 32'h100;
    tick(); idle_ctl(); lit("jr100", 32'h100, 1'b1, 1'b0);
    BranchTaken = 1'b1; BranchBase = 32'h104; BranchOffset = 32'hFFFF_FFF0;
    tick(); idle_ctl(); lit("branch_neg", 32'hF4, 1'b1, 1'b0);

    // Jump wins over branch
    Jump = 1'b1; BranchTaken = 1'b1; BranchBase = 32'h1000_0004; JumpIndex = 26'h40;
    tick(); idle_ctl(); lit("jump_prio", 32'h1000_0100, 1'b1, 1'b0);

    // Jump arriving during a 3-cycle stall
    Stall = 1'b1; Jump = 1'b1; BranchBase = 32'h4; JumpIndex = 26'h80;
    tick(); idle_ctl(); lit("stall1", 32'h1000_0100, 1'b1, 1'b0);
    tick(); lit("stall2", 32'h1000_0100, 1'b1, 1'b0);
    tick(); lit("stall3", 32'h1000_0100, 1'b1, 1'b0);
    Stall = 1'b0;
    tick(); lit("stall_rel", 32'h200, 1'b1, 1'b0);

    // Misaligned jump-register target
    JumpReg = 1'b1; JumpRegAddr = 32'h0000_0402;
    tick(); idle_ctl();
`ifdef PC_ALIGN_CHECK_EN
    lit("jr_misal", 32'h80, 1'b1, 1'b1);
    tick(); lit("jr_misal_next", 32'h84, 1'b1, 1'b0);
`else
    lit("jr_misal", 32'h400, 1'b1, 1'b0);
    tick(); lit("jr_misal_next", 32'h404, 1'b1, 1'b0);
`endif

    // Sequential wrap at the top of the address space
    JumpReg = 1'b1; JumpRegAddr = 32'hFFFF_FFFC;
    tick(); idle_ctl(); lit("wrap_pre", 32'hFFFF_FFFC, 1'b1, 1'b0);
    chk("wrap_pcplus4", PCPlus4, 32'h0);
    tick(); lit("wrap", 32'h0, 1'b1, 1'b0);

    // Memory not ready at 0x20, then reset mid-wait
    JumpReg = 1'b1; JumpRegAddr = 32'h20; ImemReady = 1'b0;
    tick(); idle_ctl(); lit("wait0", 32'h20, 1'b1, 1'b0);
    tick(); lit("wait1", 32'h20, 1'b1, 1'b0);
    tick(); lit("wait2", 32'h20, 1'b1, 1'b0);
    Rst = 1'b0;
    tick(); lit("mid_reset", RESET_PC, 1'b0, 1'b0);
    Rst = 1'b1; ImemReady = 1'b1;

    // Randomized phase, checked by the compare process against the model
    for (int i = 0; i < 3000; i++) begin
      Rst          = ($urandom_range(0, 99) != 0);
      Stall        = ($urandom_range(0, 3) == 0);
      ImemReady    = ($urandom_range(0, 3) != 0);
      BranchTaken  = ($urandom_range(0, 5) == 0);
      Jump         = ($urandom_range(0, 7) == 0);
      JumpReg      = ($urandom_range(0, 7) == 0);
      BranchBase   = $urandom;
      BranchOffset = {{14{1'b0}}, 16'($urandom), 2'b00};
      if ($urandom_range(0, 1) == 1) BranchOffset = ~BranchOffset + 32'd1;
      JumpIndex    = 26'($urandom);
      JumpRegAddr  = $urandom;
      tick();
      if (i % 500 == 0)
        $display("txn rand %0d: PC=%h valid=%0b err=%0b", i, PC, PCValid, AddrErr);
    end

    @(posedge Clk);
    @(negedge Clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_unit

// File: doc/pc_unit.md
# pc_unit

Program-counter and next-PC stage of the MIPS datapath. It consumes the word-aligned branch offset produced by the left-shift stage (sign-extended immediate shifted by 2) and forms branch, jump and jump-register targets. It holds the PC register and drives the fetch address to instruction memory through a valid/ready handshake. A one-entry redirect buffer preserves a control transfer that arrives while the pipeline is stalled.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- EXC_VECTOR, 32'h0000_0080, target on misaligned jump-register (only when alignment checking is compiled in)
- Clk  in  1  single clock, rising edge
- Rst  in  1  synchronous, active-low reset
- Stall  in  1  hazard-unit stall; PC must not advance
- ImemReady  in  1  instruction memory accepts the current fetch
- BranchBase  in  32  PC+4 of the branch/jump instruction (ID stage)
- BranchOffset  in  32  sign-extended immediate << 2
- BranchTaken  in  1  conditional branch resolved taken
- Jump  in  1  J/JAL
- JumpIndex  in  26  instr_index field
- JumpReg  in  1  JR/JALR
- JumpRegAddr  in  32  rs value
- PC  out  32  current fetch address
- PCPlus4  out  32  PC + 4
- PCValid  out  1  fetch request valid
- AddrErr  out  1  one-cycle pulse on misaligned JumpRegAddr

## Operation
- Target select, priority JumpReg > Jump > BranchTaken: JumpRegAddr; {BranchBase[31:28], JumpIndex, 2'b00}; BranchBase + BranchOffset (32-bit, wraps modulo 2^32, no overflow flag).
- Redirect = any of the three control inputs high.
- States: INIT (one cycle after reset, PCValid=0), FETCH, PENDING.
- INIT -> FETCH unconditionally; PC held at RESET_PC.
- FETCH, redirect, Stall=0: PC <= target next cycle, regardless of ImemReady; the current fetch is abandoned.
- FETCH, redirect, Stall=1: target is captured in the pending register -> PENDING; PC holds.
- FETCH, no redirect, ImemReady=1, Stall=0: PC <= PC+4 (wraps 32'hFFFF_FFFC -> 0).
- FETCH, otherwise: PC holds; PCValid stays 1.
- PENDING, Stall=1: hold; a new redirect overwrites the pending target.
- PENDING, Stall=0: PC <= new redirect target if a redirect is present, else the pending target; -> FETCH.
- Rst low in any state: INIT, pending cleared, PC=RESET_PC.

## Timing
- Reset values: PC=RESET_PC, PCPlus4=RESET_PC+4, PCValid=0, AddrErr=0.
- PCValid=1 from the second cycle after Rst deasserts.
- Redirect latency is 1 cycle (inputs in cycle N, PC=target at N+1), or the first unstalled cycle after N.
- PCPlus4 is combinational from the PC register.
- Control inputs are sampled only on rising edges; no combinational path from inputs to PC.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - JumpReg with JumpRegAddr[1:0] != 0 loads EXC_VECTOR instead of the target.
  - AddrErr pulses high in the cycle the PC is loaded.
  - This applies when the load is taken from PENDING as well.
- Not defined:
  - JumpRegAddr[1:0] is forced to 2'b00.
  - AddrErr is tied 0.

## Structure
- Shared package pc_pkg:
  - state enum (INIT, FETCH, PENDING)
  - PC width 32, instruction index width 26
  - 32'd4 increment constant
- One sub-module, pc_target_sel: combinational priority mux and adders, plus the alignment check under the macro.
- The top holds the PC register, the pending register and the FSM.

## Test plan
- Reset with RESET_PC=0, ImemReady=1 for 4 cycles after release -> PCValid 0 then 1; PC = 0, 0, 4, 8.
- PC=0x100, BranchTaken, BranchBase=0x104, BranchOffset=0xFFFF_FFF0 -> next PC=0xF4.
- Jump=1 and BranchTaken=1 together, BranchBase=0x1000_0004, JumpIndex=0x000_0040 -> PC=0x1000_0100 (jump wins).
- Stall=1 for 3 cycles with Jump to 0x200 in the first stall cycle -> PC holds; PC=0x200 on the cycle after Stall drops.
- JumpReg, JumpRegAddr=0x0000_0402:
  - with PC_ALIGN_CHECK_EN: PC=0x80, AddrErr pulses once.
  - without: PC=0x400, AddrErr=0.
- ImemReady=0 for 2 cycles at PC=0x20, then Rst low mid-wait -> PC=RESET_PC, PCValid=0 next cycle.
